// File: rtl/mux_digit_clock.sv
// HH:MM[:SS] BCD real-time clock with a button-driven time-set FSM and a multiplexed 7-segment driver.
// Optional build macro HOUR12_EN: 12-hour mode (01-12) with an extra pm output.
module mux_digit_clock #(
    parameter int CLK_HZ          = 27000000,
    parameter int REFRESH_HZ      = 1000,
    parameter int NUM_DIGITS      = 4,
    parameter bit SEG_ACTIVE_LOW  = 1'b1,
    parameter bit DIG_ACTIVE_HIGH = 1'b1
) (
    input  logic                  sys_clk,
    input  logic                  sys_rst,
    input  logic                  btn_mode,
    input  logic                  btn_inc,
    output logic [6:0]            seg,
    output logic [NUM_DIGITS-1:0] dig_sel,
    output logic                  colon,
    output logic                  set_active
`ifdef HOUR12_EN
    ,
    output logic                  pm
`endif
);

    localparam int DWELL = CLK_HZ / (REFRESH_HZ * NUM_DIGITS);
    localparam int CNT_W = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
    localparam int DW_W  = (DWELL > 1) ? $clog2(DWELL) : 1;
    localparam int IDX_W = $clog2(NUM_DIGITS);
    localparam int OFS   = (NUM_DIGITS == 6) ? 0 : 2;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLK_HZ - 1);
    localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(CLK_HZ / 2);
    localparam logic [6:0]            SEG_OFF = SEG_ACTIVE_LOW ? 7'h7F : 7'h00;
    localparam logic [NUM_DIGITS-1:0] DIG_OFF = DIG_ACTIVE_HIGH ? '0 : '1;

`ifdef HOUR12_EN
    localparam logic [3:0] HR_RST_T = 4'd1, HR_RST_O = 4'd2;
    localparam logic [3:0] HR_MAX_T = 4'd1, HR_MAX_O = 4'd2, HR_LOW_T = 4'd0, HR_LOW_O = 4'd1;
`else
    localparam logic [3:0] HR_RST_T = 4'd0, HR_RST_O = 4'd0;
    localparam logic [3:0] HR_MAX_T = 4'd2, HR_MAX_O = 4'd3, HR_LOW_T = 4'd0, HR_LOW_O = 4'd0;
`endif

    generate
        if (NUM_DIGITS != 4 && NUM_DIGITS != 6) begin : g_bad_digits
            $error("mux_digit_clock: NUM_DIGITS must be 4 or 6");
        end
    endgenerate

    typedef enum logic [1:0] {RUN, SET_HOUR, SET_MIN} state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [DW_W-1:0]  dwell_q;
    logic [IDX_W-1:0] idx_q;
    logic [3:0]       sec_t, sec_o, min_t, min_o, hr_t, hr_o;
    logic [7:0]       sec_next, min_next, hr_next;
    logic             sec_tick, blink_on, leave_set, min_adv, hour_adv;
    logic [2:0]       pos;
    logic [3:0]       cur;
    logic             blank;
    logic [6:0]       pattern, seg_d;
    logic [NUM_DIGITS-1:0] onehot;

    // Two-digit BCD increment that wraps from {tmax,omax} back to {tlow,olow}.
    function automatic logic [7:0] bcd_inc(input logic [3:0] t, o, tmax, omax, tlow, olow);
        if (t == tmax && o == omax) return {tlow, olow};
        else if (o == 4'd9)         return {t + 4'd1, 4'd0};
        else                        return {t, o + 4'd1};
    endfunction

    function automatic logic [6:0] decode(input logic [3:0] v);
        case (v)
            4'd0: return 7'h3F;  4'd1: return 7'h06;  4'd2: return 7'h5B;
            4'd3: return 7'h4F;  4'd4: return 7'h66;  4'd5: return 7'h6D;
            4'd6: return 7'h7D;  4'd7: return 7'h07;  4'd8: return 7'h7F;
            4'd9: return 7'h6F;  default: return 7'h00;
        endcase
    endfunction

    // NOTE: every signal written here gets a default first, so no path can infer a latch.
    always_comb begin
        state_d = state_q;
        case (state_q)
            RUN:      if (btn_mode) state_d = SET_HOUR;
            SET_HOUR: if (btn_mode) state_d = SET_MIN;
            SET_MIN:  if (btn_mode) state_d = RUN;
            default:  state_d = RUN;
        endcase

        leave_set = (state_q == SET_MIN) && btn_mode;
        sec_tick  = (state_q == RUN) && (cnt_q == CNT_LAST);
        blink_on  = cnt_q < CNT_HALF;
        cnt_d     = (leave_set || cnt_q == CNT_LAST) ? '0 : cnt_q + CNT_W'(1);

        sec_next = bcd_inc(sec_t, sec_o, 4'd5, 4'd9, 4'd0, 4'd0);
        min_next = bcd_inc(min_t, min_o, 4'd5, 4'd9, 4'd0, 4'd0);
        hr_next  = bcd_inc(hr_t, hr_o, HR_MAX_T, HR_MAX_O, HR_LOW_T, HR_LOW_O);

        // Mode wins over inc when both pulse together.
        min_adv  = (sec_tick && {sec_t, sec_o} == 8'h59)
                 || (state_q == SET_MIN && btn_inc && !btn_mode);
        hour_adv = (sec_tick && {sec_t, sec_o} == 8'h59 && {min_t, min_o} == 8'h59)
                 || (state_q == SET_HOUR && btn_inc && !btn_mode);
    end

    always_comb begin
        pos = 3'(idx_q) + 3'(OFS);
        cur = 4'd0;
        case (pos)
            3'd0: cur = sec_o;
            3'd1: cur = sec_t;
            3'd2: cur = min_o;
            3'd3: cur = min_t;
            3'd4: cur = hr_o;
            3'd5: cur = hr_t;
            default: cur = 4'd0;
        endcase
        blank = !blink_on && ((state_q == SET_HOUR && pos >= 3'd4) ||
                              (state_q == SET_MIN && (pos == 3'd2 || pos == 3'd3)));
        pattern = blank ? 7'h00 : decode(cur);
        seg_d   = SEG_ACTIVE_LOW ? ~pattern : pattern;
        onehot  = {{(NUM_DIGITS-1){1'b0}}, 1'b1} << idx_q;
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge sys_clk) begin
        // NOTE: reset is synchronous; it also aborts any edit in progress.
        if (sys_rst) begin
            state_q    <= RUN;
            cnt_q      <= '0;
            dwell_q    <= '0;
            idx_q      <= '0;
            {sec_t, sec_o} <= 8'h00;
            {min_t, min_o} <= 8'h00;
            {hr_t, hr_o}   <= {HR_RST_T, HR_RST_O};
            seg        <= SEG_OFF;
            dig_sel    <= DIG_OFF;
            colon      <= 1'b0;
            set_active <= 1'b0;
`ifdef HOUR12_EN
            pm         <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            set_active <= (state_d != RUN);
            colon      <= (state_d != RUN) || (cnt_d < CNT_HALF);

            if (leave_set)     {sec_t, sec_o} <= 8'h00;
            else if (sec_tick) {sec_t, sec_o} <= sec_next;
            if (min_adv)       {min_t, min_o} <= min_next;
            if (hour_adv)      {hr_t, hr_o}   <= hr_next;
`ifdef HOUR12_EN
            if (hour_adv && {hr_t, hr_o} == 8'h11) pm <= ~pm;
`endif

            // Outputs come from the pre-edge index so seg and dig_sel switch on the same edge.
            seg     <= seg_d;
            dig_sel <= DIG_ACTIVE_HIGH ? onehot : ~onehot;
            if (dwell_q == DW_W'(DWELL - 1)) begin
                dwell_q <= '0;
                idx_q   <= (idx_q == IDX_W'(NUM_DIGITS - 1)) ? '0 : idx_q + IDX_W'(1);
            end else begin
                dwell_q <= dwell_q + DW_W'(1);
            end
        end
    end

endmodule

// File: doc/mux_digit_clock.md
Name: mux_digit_clock

Overview:
Parametrised HH:MM[:SS] real-time clock with a time-multiplexed common-cathode/anode 7-segment driver.
- Successor to the fixed 4-digit clock: configurable digit count, clock rate, refresh rate and drive polarity.
- Adds a button-driven time-set state machine, field blinking and a colon output.
- Sits at top level between the board's 27 MHz oscillator, pre-debounced push-button pulses and the display pins.

Parameters:
CLK_HZ, 27000000, sys_clk frequency; sets the 1 Hz prescaler terminal count.
REFRESH_HZ, 1000, full-display refresh rate; per-digit dwell = CLK_HZ/(REFRESH_HZ*NUM_DIGITS) cycles.
NUM_DIGITS, 4, 4 = HH:MM, 6 = HH:MM:SS; any other value is an elaboration error.
SEG_ACTIVE_LOW, 1, 1 = segment lit when driven 0.
DIG_ACTIVE_HIGH, 1, 1 = digit selected when driven 1.

Ports:
sys_clk  in  1  system clock, all logic on rising edge.
sys_rst  in  1  reset; synchronous, active-high.
btn_mode  in  1  one-cycle pulse, pre-debounced; advances set-mode FSM.
btn_inc  in  1  one-cycle pulse, pre-debounced; increments the selected field.
seg  out  7  segments; bit0=a … bit6=g; polarity per SEG_ACTIVE_LOW.
dig_sel  out  NUM_DIGITS  one-hot digit select; bit0 = rightmost digit.
colon  out  1  colon LED, active-high.
set_active  out  1  high in any SET state.

Behaviour:
- Reset (sync, one cycle): time 00:00:00, FSM=RUN, prescaler=0, refresh counter/index=0, seg all unlit, dig_sel all inactive, colon=0, set_active=0. A reset asserted mid-set-mode aborts the edit.
- Prescaler counts 0..CLK_HZ-1 and then wraps; sec_tick when count==CLK_HZ-1. blink_on = (count < CLK_HZ/2).
- Time is held as BCD digits: sec 00-59, min 00-59, hour 00-23. Carries resolve in the sec_tick cycle: xx:xx:59→min+1, xx:59:59→hour+1, 23:59:59→00:00:00.
- FSM states: RUN, SET_HOUR, SET_MIN. btn_mode sequence: RUN→SET_HOUR→SET_MIN→RUN.
- In SET states, sec_tick is suppressed and the prescaler keeps running for blink timing.
- btn_inc in SET_HOUR: hour+1, wrapping 23→00. btn_inc in SET_MIN: min+1, wrapping 59→00. No carry in either case.
- btn_inc in RUN is ignored.
- Transition SET_MIN→RUN clears sec to 00 and prescaler to 0.
- btn_mode and btn_inc in the same cycle: mode wins, inc is dropped.
- Refresh: dwell counter 0..DWELL-1; the digit index advances 0..NUM_DIGITS-1 and wraps.
- Digit map, 4 digits: [0]=min ones, [1]=min tens, [2]=hour ones, [3]=hour tens. With 6 digits, seconds occupy [0],[1] and min/hour shift up by 2.
- seg and dig_sel are registered together from the current index, one cycle after the index changes. No ghosting: both update in the same edge.
- Decode: standard 0-9 patterns. No leading-zero suppression.
- Blink: in SET_HOUR, hour digits are unlit while !blink_on; SET_MIN does the same for minute digits. dig_sel is unaffected by blinking.
- colon = blink_on in RUN; constant 1 in SET states.
- set_active is registered and equals (state != RUN).

Optional Feature:
HOUR12_EN defined:
- 12-hour mode; hour ranges 01-12; reset value 12:00:00 with pm=0.
- Extra output port pm (1 bit, active-high). pm toggles on 11:59:59→12:00:00; 12:59:59→01:00:00 leaves pm unchanged.
- SET_HOUR increments 12→01; 11→12 toggles pm.
Not defined: 24-hour behaviour as above; the pm port does not exist.

Test Plan:
- CLK_HZ=100, REFRESH_HZ=5, NUM_DIGITS=4: reset, run 6000 cycles -> time 00:01:00. Minute-ones digit shows seg=7'b1111001 ("1", active-low).
- Set 23:59 via mode/inc pulses, return to RUN, run 6000 cycles -> 00:00:00 rollover; hour tens seg=7'b1000000.
- SET_MIN with min=59, pulse btn_inc -> min=00, hour unchanged, set_active=1, minute digits unlit while count>=50.
- btn_mode and btn_inc pulsed together in RUN -> state SET_HOUR, hour unchanged.
- Scan check: dig_sel sequence 0001,0010,0100,1000, each held 5 cycles, seg valid on the same edge; colon high for cycles 0-49 of each second.
- Assert sys_rst for one cycle while in SET_HOUR with hour=07 -> next cycle RUN, 00:00:00, dig_sel=0000, seg=7'b1111111.
